// File: rtl/prbs_err_counter_bank.sv
// prbs_err_counter_bank: per-channel saturating/wrapping error counters with sticky overflow, LED level and registered readout
module prbs_err_counter_bank #(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  parameter int WRAP = 0,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             freeze,
  input  logic [NCH-1:0]   inc,
  input  logic [NCH-1:0]   clr_ch,
  input  logic             clr_all,
  input  logic [SW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic [NCH-1:0]   cnt_max,
  output logic [NCH-1:0]   ovf_sticky,
  output logic [2*NCH-1:0] led_lvl,
  output logic             any_err
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH / 2);
  logic [WIDTH-1:0] cnt [NCH];
  logic [NCH-1:0] nz;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // clear beats freeze, freeze beats a gated increment; overflow only on an accepted event at MAX
    always_ff @(posedge clk)
      if (rst || clr_all || clr_ch[i]) begin
        cnt[i] <= '0;
        ovf_sticky[i] <= 1'b0;
      end else if (!freeze && enable && inc[i]) begin
        cnt[i] <= (cnt[i] != MAX) ? cnt[i] + 1'b1 : ((WRAP != 0) ? '0 : MAX);
        ovf_sticky[i] <= ovf_sticky[i] | (cnt[i] == MAX);
      end
    assign cnt_max[i] = cnt[i] == MAX;
    assign nz[i] = cnt[i] != '0;
    assign led_lvl[2*i +: 2] = (cnt_max[i] || ovf_sticky[i]) ? 2'd3 :
                               (cnt[i] >= HALF) ? 2'd2 : nz[i] ? 2'd1 : 2'd0;
  end
  assign any_err = |{ovf_sticky, nz};
  // registered readout; out-of-range selects read as zero
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      rd_ovf <= 1'b0;
    end else begin
      rd_data <= ({1'b0, rd_sel} < (SW+1)'(NCH)) ? cnt[rd_sel] : '0;
      rd_ovf <= ({1'b0, rd_sel} < (SW+1)'(NCH)) ? ovf_sticky[rd_sel] : 1'b0;
    end
endmodule

// File: tb/tb_prbs_err_counter_bank.sv
// tb_prbs_err_counter_bank: three configurations driven in parallel and checked against a counting model
module tb_prbs_err_counter_bank;
  logic clk = 0, rst = 0, enable = 0, freeze = 0, clr_all = 0;
  logic [3:0] inc = 0, clr_ch = 0;
  logic [1:0] rd_sel = 0;
  logic [7:0] rd0;
  logic [1:0] rd1, rd2;
  logic ro0, ro1, ro2, ae0, ae1, ae2;
  logic [3:0] cm0, cm1, ov0, ov1;
  logic [2:0] cm2, ov2;
  logic [7:0] led0, led1;
  logic [5:0] led2;
  logic [31:0] o_cm [3], o_ov [3], o_led [3], o_any [3], o_rd [3], o_ro [3];
  int nch [3] = '{4, 4, 3};
  int wd [3] = '{8, 2, 2};
  int wr [3] = '{0, 0, 1};
  int mc [3][4];
  bit mo [3][4];
  int mrd [3];
  int mro [3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  prbs_err_counter_bank #(.NCH(4), .WIDTH(8), .WRAP(0)) d8 (.clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .inc(inc), .clr_ch(clr_ch), .clr_all(clr_all), .rd_sel(rd_sel), .rd_data(rd0), .rd_ovf(ro0),
    .cnt_max(cm0), .ovf_sticky(ov0), .led_lvl(led0), .any_err(ae0));
  prbs_err_counter_bank #(.NCH(4), .WIDTH(2), .WRAP(0)) d2s (.clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .inc(inc), .clr_ch(clr_ch), .clr_all(clr_all), .rd_sel(rd_sel), .rd_data(rd1), .rd_ovf(ro1),
    .cnt_max(cm1), .ovf_sticky(ov1), .led_lvl(led1), .any_err(ae1));
  prbs_err_counter_bank #(.NCH(3), .WIDTH(2), .WRAP(1)) d2w (.clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .inc(inc[2:0]), .clr_ch(clr_ch[2:0]), .clr_all(clr_all), .rd_sel(rd_sel), .rd_data(rd2), .rd_ovf(ro2),
    .cnt_max(cm2), .ovf_sticky(ov2), .led_lvl(led2), .any_err(ae2));
  always_comb begin
    o_cm[0] = 32'(cm0); o_cm[1] = 32'(cm1); o_cm[2] = 32'(cm2);
    o_ov[0] = 32'(ov0); o_ov[1] = 32'(ov1); o_ov[2] = 32'(ov2);
    o_led[0] = 32'(led0); o_led[1] = 32'(led1); o_led[2] = 32'(led2);
    o_any[0] = 32'(ae0); o_any[1] = 32'(ae1); o_any[2] = 32'(ae2);
    o_rd[0] = 32'(rd0); o_rd[1] = 32'(rd1); o_rd[2] = 32'(rd2);
    o_ro[0] = 32'(ro0); o_ro[1] = 32'(ro1); o_ro[2] = 32'(ro2);
  end
  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int mx, s;
      mx = (1 << wd[k]) - 1;
      s = int'(rd_sel);
      mrd[k] = (rst || s >= nch[k]) ? 0 : mc[k][s];
      mro[k] = (rst || s >= nch[k]) ? 0 : int'(mo[k][s]);
      for (int i = 0; i < nch[k]; i++)
        if (rst || clr_all || clr_ch[i]) begin
          mc[k][i] = 0;
          mo[k][i] = 0;
        end else if (!freeze && enable && inc[i]) begin
          if (mc[k][i] < mx) mc[k][i] = mc[k][i] + 1;
          else begin
            mo[k][i] = 1;
            mc[k][i] = wr[k] ? 0 : mx;
          end
        end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] ecm, eov, eled, eany;
      int mx, lvl;
      mx = (1 << wd[k]) - 1;
      ecm = 0; eov = 0; eled = 0; eany = 0;
      for (int i = 0; i < nch[k]; i++) begin
        if (mc[k][i] == mx) ecm[i] = 1;
        if (mo[k][i]) eov[i] = 1;
        if (mc[k][i] != 0 || mo[k][i]) eany = 1;
        lvl = (mc[k][i] == mx || mo[k][i]) ? 3 : (mc[k][i] >= (1 << (wd[k] / 2))) ? 2 : (mc[k][i] >= 1) ? 1 : 0;
        eled = eled | (32'(lvl) << (2 * i));
      end
      chk("cnt_max", k, o_cm[k], ecm);
      chk("ovf_sticky", k, o_ov[k], eov);
      chk("led_lvl", k, o_led[k], eled);
      chk("any_err", k, o_any[k], eany);
      chk("rd_data", k, o_rd[k], 32'(mrd[k]));
      chk("rd_ovf", k, o_ro[k], 32'(mro[k]));
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      mrd[k] = 0; mro[k] = 0;
      for (int i = 0; i < 4; i++) begin mc[k][i] = 0; mo[k][i] = 0; end
    end
    #1;
    rst = 1; step(); step(); rst = 0;
    chk("reset_led", 0, o_led[0], 0);
    enable = 1; inc = 4'b0001;
    repeat (5) step();
    chk("t1_led0", 0, 32'(led0[1:0]), 1);
    chk("t1_any", 0, o_any[0], 1);
    inc = 0; rd_sel = 0; step();
    chk("t1_rd", 0, o_rd[0], 5);
    inc = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("t2_cm1", 1, 32'(cm1[1]), (c >= 3) ? 1 : 0);
      chk("t2_ov1", 1, 32'(ov1[1]), (c >= 4) ? 1 : 0);
    end
    chk("t2_led", 1, 32'(led1[3:2]), 3);
    inc = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("t3_ov2", 2, 32'(ov2[2]), (c >= 4) ? 1 : 0);
    end
    chk("t3_led", 2, 32'(led2[5:4]), 3);
    inc = 0; rd_sel = 2; step();
    chk("t3_rd", 2, o_rd[2], 1);
    inc = 4'b1000;
    repeat (7) step();
    inc = 0; rd_sel = 3; step();
    chk("t4_rd7", 0, o_rd[0], 7);
    clr_ch = 4'b1000; inc = 4'b1000; step();
    clr_ch = 0; inc = 0; step();
    chk("t4_rd0", 0, o_rd[0], 0);
    chk("t4_ov3", 0, 32'(ov0[3]), 0);
    clr_all = 1; step(); clr_all = 0;
    chk("t4_any0", 0, o_any[0], 0);
    chk("t4_any1", 1, o_any[1], 0);
    chk("t4_any2", 2, o_any[2], 0);
    inc = 4'b0001; repeat (4) step();
    freeze = 1; repeat (3) step();
    freeze = 0; enable = 0; step();
    enable = 1; rd_sel = 0; step();
    inc = 0; step();
    chk("t5_rd", 0, o_rd[0], 5);
    repeat (300) begin
      rst = ($urandom_range(0, 99) == 0);
      clr_all = ($urandom_range(0, 49) == 0);
      clr_ch = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      freeze = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 19) != 0);
      inc = 4'($urandom);
      rd_sel = 2'($urandom);
      step();
    end
    rst = 0; clr_all = 0; clr_ch = 0; freeze = 0; enable = 1; inc = 4'b1111;
    repeat (3) step();
    rd_sel = 3; step();
    chk("t6_rd_oor", 2, o_rd[2], 0);
    chk("t6_ro_oor", 2, o_ro[2], 0);
    rst = 1; freeze = 1; clr_ch = 4'b0101; step();
    chk("t6_rst_any", 0, o_any[0], 0);
    chk("t6_rst_led", 1, o_led[1], 0);
    rst = 0; freeze = 0; clr_ch = 0; inc = 0; step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
